// File: rtl/eth_xcvr_drp_arbiter.sv
// Two-requester arbiter for a single transceiver DRP port: round-robin grant,
// lock for read-modify-write sequences, rdy timeout with a saturating abort counter.
module eth_xcvr_drp_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        xcvr_ctrl_clk,
    input  logic        xcvr_ctrl_rst,
    input  logic        s0_req,
    input  logic        s0_we,
    input  logic [9:0]  s0_addr,
    input  logic [15:0] s0_di,
    input  logic        s0_lock,
    output logic [15:0] s0_do,
    output logic        s0_ack,
    output logic        s0_err,
    input  logic        s1_req,
    input  logic        s1_we,
    input  logic [9:0]  s1_addr,
    input  logic [15:0] s1_di,
    input  logic        s1_lock,
    output logic [15:0] s1_do,
    output logic        s1_ack,
    output logic        s1_err,
    output logic        drp_en,
    output logic        drp_we,
    output logic [9:0]  drp_addr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_rdy,
    output logic        busy,
    output logic [7:0]  timeout_count
);

    localparam logic [2:0]  ST_IDLE    = 3'd0;
    localparam logic [2:0]  ST_ISSUE   = 3'd1;
    localparam logic [2:0]  ST_WAIT    = 3'd2;
    localparam logic [2:0]  ST_DONE    = 3'd3;
    localparam logic [2:0]  ST_LOCKED  = 3'd4;
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 32'd1);

    logic [2:0]  state_r, state_s;
    logic        g_r, g_s, p_r, p_s;
    logic [15:0] timer_r, timer_s;
    logic        drp_en_r, drp_en_s, drp_we_r, drp_we_s;
    logic [9:0]  drp_addr_r, drp_addr_s;
    logic [15:0] drp_di_r, drp_di_s;
    logic [15:0] s0_do_r, s0_do_s, s1_do_r, s1_do_s;
    logic        s0_ack_r, s0_ack_s, s1_ack_r, s1_ack_s;
    logic        s0_err_r, s0_err_s, s1_err_r, s1_err_s;
    logic        busy_r, busy_s;
    logic [7:0]  tcount_r, tcount_s;
    logic        grant_valid_s, grant_s, sel_idx_s;
    logic        sel_we_s, sg_req_s, sg_lock_s;
    logic [9:0]  sel_addr_s;
    logic [15:0] sel_di_s, rsp_do_s;
    logic        rsp_err_s, done_s;

    // Idle arbitration: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = g_r;
        if (s0_req && s1_req) begin
            grant_valid_s = 1'b1;
            grant_s       = p_r;
        end else if (s0_req) begin
            grant_valid_s = 1'b1;
            grant_s       = 1'b0;
        end else if (s1_req) begin
            grant_valid_s = 1'b1;
            grant_s       = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_s       = g_r;
        end
    end

    // Field capture source: the new winner in IDLE, the lock holder otherwise.
    always_comb begin
        sel_idx_s  = (state_r == ST_IDLE) ? grant_s : g_r;
        sel_we_s   = sel_idx_s ? s1_we   : s0_we;
        sel_addr_s = sel_idx_s ? s1_addr : s0_addr;
        sel_di_s   = sel_idx_s ? s1_di   : s0_di;
        sg_req_s   = g_r ? s1_req  : s0_req;
        sg_lock_s  = g_r ? s1_lock : s0_lock;
    end

    // Transaction sequencing and next values for every registered output.
    always_comb begin
        state_s    = state_r;
        g_s        = g_r;
        p_s        = p_r;
        timer_s    = timer_r;
        drp_en_s   = 1'b0;
        drp_we_s   = drp_we_r;
        drp_addr_s = drp_addr_r;
        drp_di_s   = drp_di_r;
        s0_do_s    = s0_do_r;
        s1_do_s    = s1_do_r;
        s0_ack_s   = 1'b0;
        s1_ack_s   = 1'b0;
        s0_err_s   = s0_err_r;
        s1_err_s   = s1_err_r;
        tcount_s   = tcount_r;
        rsp_do_s   = 16'hFFFF;
        rsp_err_s  = 1'b1;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    g_s        = grant_s;
                    p_s        = (s0_req && s1_req) ? ~p_r : p_r;
                    drp_en_s   = 1'b1;
                    drp_we_s   = sel_we_s;
                    drp_addr_s = sel_addr_s;
                    drp_di_s   = sel_di_s;
                    state_s    = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                timer_s = 16'd0;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // rdy wins over a coincident timeout
                if (drp_rdy) begin
                    done_s    = 1'b1;
                    rsp_do_s  = drp_do;
                    rsp_err_s = 1'b0;
                end else if (timer_r == TIMER_LAST) begin
                    done_s    = 1'b1;
                    rsp_do_s  = 16'hFFFF;
                    rsp_err_s = 1'b1;
                    tcount_s  = (tcount_r == 8'hFF) ? tcount_r : tcount_r + 8'd1;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
                state_s = done_s ? ST_DONE : ST_WAIT;
            end
            ST_DONE: begin
                state_s = sg_lock_s ? ST_LOCKED : ST_IDLE;
            end
            ST_LOCKED: begin
                if (sg_req_s) begin
                    drp_en_s   = 1'b1;
                    drp_we_s   = sel_we_s;
                    drp_addr_s = sel_addr_s;
                    drp_di_s   = sel_di_s;
                    state_s    = ST_ISSUE;
                end else if (!sg_lock_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (done_s) begin
            if (g_r) begin
                s1_do_s  = rsp_do_s;
                s1_err_s = rsp_err_s;
                s1_ack_s = 1'b1;
            end else begin
                s0_do_s  = rsp_do_s;
                s0_err_s = rsp_err_s;
                s0_ack_s = 1'b1;
            end
        end else begin
            s0_ack_s = 1'b0;
            s1_ack_s = 1'b0;
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge xcvr_ctrl_clk) begin
        if (xcvr_ctrl_rst) begin
            state_r    <= ST_IDLE;
            g_r        <= 1'b0;
            p_r        <= 1'b0;
            timer_r    <= 16'd0;
            drp_en_r   <= 1'b0;
            drp_we_r   <= 1'b0;
            drp_addr_r <= 10'd0;
            drp_di_r   <= 16'd0;
            s0_do_r    <= 16'd0;
            s1_do_r    <= 16'd0;
            s0_ack_r   <= 1'b0;
            s1_ack_r   <= 1'b0;
            s0_err_r   <= 1'b0;
            s1_err_r   <= 1'b0;
            busy_r     <= 1'b0;
            tcount_r   <= 8'd0;
        end else begin
            state_r    <= state_s;
            g_r        <= g_s;
            p_r        <= p_s;
            timer_r    <= timer_s;
            drp_en_r   <= drp_en_s;
            drp_we_r   <= drp_we_s;
            drp_addr_r <= drp_addr_s;
            drp_di_r   <= drp_di_s;
            s0_do_r    <= s0_do_s;
            s1_do_r    <= s1_do_s;
            s0_ack_r   <= s0_ack_s;
            s1_ack_r   <= s1_ack_s;
            s0_err_r   <= s0_err_s;
            s1_err_r   <= s1_err_s;
            busy_r     <= busy_s;
            tcount_r   <= tcount_s;
        end
    end

    assign drp_en        = drp_en_r;
    assign drp_we        = drp_we_r;
    assign drp_addr      = drp_addr_r;
    assign drp_di        = drp_di_r;
    assign s0_do         = s0_do_r;
    assign s1_do         = s1_do_r;
    assign s0_ack        = s0_ack_r;
    assign s1_ack        = s1_ack_r;
    assign s0_err        = s0_err_r;
    assign s1_err        = s1_err_r;
    assign busy          = busy_r;
    assign timeout_count = tcount_r;

endmodule

// File: tb/tb_eth_xcvr_drp_arbiter.sv
// Bench for eth_xcvr_drp_arbiter: transaction-timing model checked every cycle,
// plus literal expectations for the read, contention, timeout, lock, reset and saturation cases.
module tb_eth_xcvr_drp_arbiter;

    localparam int TMO = 16;

    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [15:0] di;
        logic        lock;
        logic        early;
    } txn_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req, we, lock;
    logic [9:0]  addr [2];
    logic [15:0] di [2];
    logic [15:0] rsp_data;
    logic        rsp_rdy, man_rdy, drp_rdy;
    logic [15:0] s0_do, s1_do, drp_di;
    logic        s0_ack, s0_err, s1_ack, s1_err, drp_en, drp_we, busy;
    logic [9:0]  drp_addr;
    logic [7:0]  timeout_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rsp_delay = 3;
    int rsp_cnt  = 0;
    int done_cnt [2] = '{0, 0};
    int last_en_cyc = 0;
    int last_ack_cyc [2] = '{0, 0};
    int en_cnt = 0;
    int ack_seq [$];
    txn_t q0 [$];
    txn_t q1 [$];

    // model state: 0 = free, 1 = held by lock, 2 = transaction in flight
    int          m_mode = 0;
    int          m_own = 0, m_lock_own = 0, m_issue = -10, m_ack = -10;
    bit          m_ptr = 1'b0, m_jerr = 1'b0, mvalid = 1'b0;
    logic        m_jwe = 1'b0;
    logic [9:0]  m_jaddr = 10'd0;
    logic [15:0] m_jdi = 16'd0, m_jdo = 16'd0;
    bit          e_en = 1'b0, e_busy = 1'b0;
    bit [1:0]    e_ack = 2'b00, e_err = 2'b00;
    logic [15:0] e_do [2] = '{16'd0, 16'd0};
    int          e_cnt = 0;

    assign drp_rdy = rsp_rdy | man_rdy;

    eth_xcvr_drp_arbiter #(.TIMEOUT(TMO)) dut (
        .xcvr_ctrl_clk (clk),
        .xcvr_ctrl_rst (rst),
        .s0_req (req[0]), .s0_we (we[0]), .s0_addr (addr[0]), .s0_di (di[0]), .s0_lock (lock[0]),
        .s0_do (s0_do), .s0_ack (s0_ack), .s0_err (s0_err),
        .s1_req (req[1]), .s1_we (we[1]), .s1_addr (addr[1]), .s1_di (di[1]), .s1_lock (lock[1]),
        .s1_do (s1_do), .s1_ack (s1_ack), .s1_err (s1_err),
        .drp_en (drp_en), .drp_we (drp_we), .drp_addr (drp_addr), .drp_di (drp_di),
        .drp_do (rsp_data), .drp_rdy (drp_rdy),
        .busy (busy), .timeout_count (timeout_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int w, input logic w_we, input logic [9:0] a, input logic [15:0] d,
                        input logic lk, input logic early);
        txn_t t;
        t.we = w_we; t.addr = a; t.di = d; t.lock = lk; t.early = early;
        if (w == 0) q0.push_back(t);
        else        q1.push_back(t);
    endtask

    task automatic start_job(input int w);
        m_mode  = 2;
        m_own   = w;
        m_issue = cyc;
        m_jwe   = we[w];
        m_jaddr = addr[w];
        m_jdi   = di[w];
        if (rsp_delay != 0 && rsp_delay <= TMO) begin
            m_ack  = cyc + rsp_delay + 1;
            m_jerr = 1'b0;
            m_jdo  = rsp_data;
        end else begin
            m_ack  = cyc + TMO + 1;
            m_jerr = 1'b1;
            m_jdo  = 16'hFFFF;
        end
    endtask

    // Behavioural model: decides what the cycle starting at this edge must show.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            e_ack = 2'b00;
            if (rst) begin
                m_mode = 0; m_ptr = 1'b0; e_do[0] = 16'd0; e_do[1] = 16'd0;
                e_err = 2'b00; e_cnt = 0; mvalid = 1'b1;
            end else if (mvalid) begin
                if (m_mode == 0) begin
                    if (req == 2'b11) begin
                        start_job(int'(m_ptr));
                        m_ptr = ~m_ptr;
                    end else if (req == 2'b01) begin
                        start_job(0);
                    end else if (req == 2'b10) begin
                        start_job(1);
                    end
                end else if (m_mode == 1) begin
                    if (req[m_lock_own]) start_job(m_lock_own);
                    else if (!lock[m_lock_own]) m_mode = 0;
                end else if (cyc - 1 == m_ack) begin
                    m_lock_own = m_own;
                    m_mode = lock[m_own] ? 1 : 0;
                end
                if (m_mode == 2 && cyc == m_ack) begin
                    e_ack[m_own] = 1'b1;
                    e_do[m_own]  = m_jdo;
                    e_err[m_own] = m_jerr;
                    if (m_jerr && e_cnt < 255) e_cnt++;
                end
            end
            e_en   = (m_mode == 2 && cyc == m_issue);
            e_busy = (m_mode != 0);
        end
    end

    // Per-cycle compare against the model, plus event bookkeeping.
    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                chk("drp_en", 32'(drp_en), 32'(e_en));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("s0_ack", 32'(s0_ack), 32'(e_ack[0]));
                chk("s1_ack", 32'(s1_ack), 32'(e_ack[1]));
                chk("s0_do", 32'(s0_do), 32'(e_do[0]));
                chk("s1_do", 32'(s1_do), 32'(e_do[1]));
                chk("s0_err", 32'(s0_err), 32'(e_err[0]));
                chk("s1_err", 32'(s1_err), 32'(e_err[1]));
                chk("timeout_count", 32'(timeout_count), 32'(e_cnt));
                if (e_en) begin
                    chk("drp_we", 32'(drp_we), 32'(m_jwe));
                    chk("drp_addr", 32'(drp_addr), 32'(m_jaddr));
                    chk("drp_di", 32'(drp_di), 32'(m_jdi));
                end
            end
            if (drp_en) begin last_en_cyc = cyc; en_cnt++; end
            if (s0_ack) begin last_ack_cyc[0] = cyc; ack_seq.push_back(0); end
            if (s1_ack) begin last_ack_cyc[1] = cyc; ack_seq.push_back(1); end
        end
    end

    // Transceiver responder: rdy pulse rsp_delay cycles after drp_en (0 = never).
    initial begin
        rsp_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                rsp_rdy = (rsp_cnt == 0);
            end else begin
                rsp_rdy = 1'b0;
            end
            if (drp_en) rsp_cnt = rsp_delay;
        end
    end

    task automatic master(input int w);
        txn_t t;
        bit   got, ackd, aborted;
        int   k;
        forever begin
            @(posedge clk); #1;
            got = 1'b0;
            if (w == 0 && q0.size() > 0) begin t = q0.pop_front(); got = 1'b1; end
            else if (w == 1 && q1.size() > 0) begin t = q1.pop_front(); got = 1'b1; end
            if (got) begin
                req[w] = 1'b1; we[w] = t.we; addr[w] = t.addr; di[w] = t.di; lock[w] = t.lock;
                k = 0; ackd = 1'b0; aborted = 1'b0;
                while (!ackd && !aborted && k < 400) begin
                    @(posedge clk); #1;
                    k++;
                    if (rst) aborted = 1'b1;
                    if (t.early && k == 1) req[w] = 1'b0;
                    if ((w == 0) ? s0_ack : s1_ack) ackd = 1'b1;
                end
                req[w] = 1'b0;
                if (ackd) done_cnt[w]++;
                if (!aborted) chk("ack_wait", 32'(ackd), 32'd1);
            end
        end
    endtask

    initial master(0);
    initial master(1);

    task automatic wait_done(input int n0, input int n1, input int budget);
        int k = 0;
        while ((done_cnt[0] < n0 || done_cnt[1] < n1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_wait", 32'(done_cnt[0] >= n0 && done_cnt[1] >= n1), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n, k;
        rst = 1'b1; req = 2'b00; we = 2'b00; lock = 2'b00; man_rdy = 1'b0;
        addr[0] = 10'd0; addr[1] = 10'd0; di[0] = 16'd0; di[1] = 16'd0; rsp_data = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drp_en", 32'(drp_en), 32'd0);
        chk("rst_drp_we", 32'(drp_we), 32'd0);
        chk("rst_drp_addr", 32'(drp_addr), 32'd0);
        chk("rst_drp_di", 32'(drp_di), 32'd0);
        chk("rst_s1_do", 32'(s1_do), 32'd0);
        rst = 1'b0;

        // single read
        rsp_delay = 3; rsp_data = 16'h1234;
        push(0, 1'b0, 10'h07C, 16'h0000, 1'b0, 1'b0);
        wait_done(1, 0, 100);
        chk("rd_s0_do", 32'(s0_do), 32'h1234);
        chk("rd_s0_err", 32'(s0_err), 32'd0);
        chk("rd_latency", 32'(last_ack_cyc[0] - last_en_cyc), 32'd4);
        chk("rd_en_cnt", 32'(en_cnt), 32'd1);

        // contention: s0 wins the tie, s1 next, then s0 re-request
        rsp_delay = 2; rsp_data = 16'h5A5A;
        push(0, 1'b0, 10'h100, 16'h0000, 1'b0, 1'b0);
        push(0, 1'b1, 10'h101, 16'h1111, 1'b0, 1'b0);
        push(1, 1'b1, 10'h3FF, 16'hBEEF, 1'b0, 1'b0);
        wait_done(3, 1, 200);
        chk("cont_order_a", 32'(ack_seq[1]), 32'd0);
        chk("cont_order_b", 32'(ack_seq[2]), 32'd1);
        chk("cont_order_c", 32'(ack_seq[3]), 32'd0);
        chk("cont_en_cnt", 32'(en_cnt), 32'd4);

        // timeout, then a late rdy that must be ignored
        rsp_delay = 0;
        push(1, 1'b0, 10'h011, 16'h0000, 1'b0, 1'b0);
        wait_done(3, 2, 200);
        chk("tmo_latency", 32'(last_ack_cyc[1] - last_en_cyc), 32'd17);
        chk("tmo_s1_err", 32'(s1_err), 32'd1);
        chk("tmo_s1_do", 32'(s1_do), 32'hFFFF);
        chk("tmo_count", 32'(timeout_count), 32'd1);
        man_rdy = 1'b1;
        @(negedge clk);
        man_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_rdy_busy", 32'(busy), 32'd0);
        chk("late_rdy_count", 32'(timeout_count), 32'd1);

        // rdy on the timeout cycle wins; one cycle later is an abort
        rsp_delay = TMO; rsp_data = 16'h0F0F;
        push(0, 1'b0, 10'h022, 16'h0000, 1'b0, 1'b1);
        wait_done(4, 2, 200);
        chk("edge_latency", 32'(last_ack_cyc[0] - last_en_cyc), 32'd17);
        chk("edge_s0_err", 32'(s0_err), 32'd0);
        chk("edge_s0_do", 32'(s0_do), 32'h0F0F);
        rsp_delay = TMO + 1;
        push(1, 1'b0, 10'h023, 16'h0000, 1'b0, 1'b0);
        wait_done(4, 3, 200);
        chk("edge2_s1_err", 32'(s1_err), 32'd1);
        chk("edge2_count", 32'(timeout_count), 32'd2);

        // lock: s0 read-modify-write completes before s1
        rsp_delay = 1; rsp_data = 16'h7777;
        push(0, 1'b0, 10'h07C, 16'h0000, 1'b1, 1'b0);
        push(0, 1'b1, 10'h07C, 16'hABCD, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        push(1, 1'b0, 10'h200, 16'h0000, 1'b0, 1'b0);
        wait_done(6, 4, 200);
        n = ack_seq.size();
        chk("lock_order_a", 32'(ack_seq[n-3]), 32'd0);
        chk("lock_order_b", 32'(ack_seq[n-2]), 32'd0);
        chk("lock_order_c", 32'(ack_seq[n-1]), 32'd1);

        // reset in the middle of WAIT
        rsp_delay = 10; rsp_data = 16'h3131;
        push(0, 1'b0, 10'h030, 16'h0000, 1'b0, 1'b0);
        k = 0;
        while (!drp_en && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rst_en_seen", 32'(drp_en), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        repeat (15) @(negedge clk);
        chk("rst_mid_noack", 32'(done_cnt[0]), 32'd6);
        chk("rst_mid_count", 32'(timeout_count), 32'd0);
        rsp_delay = 2;
        push(0, 1'b0, 10'h031, 16'h0000, 1'b0, 1'b0);
        wait_done(7, 4, 200);
        chk("rst_after_do", 32'(s0_do), 32'h3131);

        // saturation of the abort counter
        rsp_delay = 0;
        for (int i = 0; i < 300; i++) push(1, 1'b0, 10'(i), 16'h0000, 1'b0, 1'b0);
        wait_done(7, 304, 9000);
        chk("sat_count", 32'(timeout_count), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
